// File: rtl/alu_pkg.sv
// Shared encodings for EX-stage ALU control and the HI/LO multiply/divide unit.
// No logic, no latency; constants and types only.
package alu_pkg;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_SLL = 4'b1000;
    localparam logic [3:0] CTL_SRL = 4'b1001;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_RTYPE = 2'b10,
        AOP_RSVD  = 2'b11
    } alu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    // Low two funct bits of the MDU group: bit1 = divide, bit0 = unsigned.
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/alu_ctl_mdu_if.sv
// EX-stage instruction/operand bus and ALU-control/MDU result bus.
// No logic; master drives instruction fields, slave returns control and HI/LO.
interface alu_ctl_mdu_if #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
);
    logic             valid_in;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [CTL_W-1:0] alu_ctl;
    logic [1:0]       hi_lo_sel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             mdu_done;

    modport master (
        output valid_in, alu_op, funct, rs_val, rt_val,
        input  alu_ctl, hi_lo_sel, hi, lo, busy, stall, mdu_done
    );

    modport slave (
        input  valid_in, alu_op, funct, rs_val, rt_val,
        output alu_ctl, hi_lo_sel, hi, lo, busy, stall, mdu_done
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply (shift-add) / divide (restoring) engine, one bit per cycle.
// Latency: WIDTH cycles after start; hi/lo visible the cycle after done.
// Backpressure: start is accepted only in IDLE; requests while busy are dropped.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  mdu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             is_div, neg_q, neg_r;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             op_signed, sa, sb, load;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_r;
    logic [WIDTH-1:0] div_d, nxt_hi, nxt_lo, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;
    logic             div_ge;

    always_comb begin
        state_nxt = state;
        case (state)
            MDU_IDLE: if (start) state_nxt = MDU_RUN;
            MDU_RUN:  if (cnt == LAST) state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
    end

    assign load      = start && (state == MDU_IDLE);
    assign busy      = (state == MDU_RUN);
    assign done      = busy && (cnt == LAST);
    assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign sa        = op_signed & a[WIDTH-1];
    assign sb        = op_signed & b[WIDTH-1];
    assign mag_a     = sa ? -a : a;
    assign mag_b     = sb ? -b : b;

    // One iteration step; the remainder always fits WIDTH bits, so the
    // subtraction can be done modulo 2^WIDTH once div_ge is known.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_r   = {acc_hi, acc_lo[WIDTH-1]};
        div_ge  = div_r >= {1'b0, opnd};
        div_d   = div_r[WIDTH-1:0] - opnd;
        if (is_div) begin
            nxt_hi = div_ge ? div_d : div_r[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod = neg_q ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
        if (is_div) begin
            res_hi = neg_r ? -nxt_hi : nxt_hi;
            res_lo = neg_q ? -nxt_lo : nxt_lo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= MDU_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt    <= '0;
                is_div <= op[1];
                // Divide-by-zero keeps the all-ones quotient unsigned.
                neg_q  <= (sa ^ sb) & ~(op[1] & (b == '0));
                neg_r  <= sa;
                acc_hi <= '0;
                acc_lo <= op[1] ? mag_a : mag_b;
                opnd   <= op[1] ? mag_b : mag_a;
            end else if (busy) begin
                cnt    <= cnt + 1'b1;
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                if (done) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_ctl_mdu.sv
// EX-stage ALU-control decode plus HI/LO multiply/divide unit with stall output.
// Latency: decode combinational; MDU result WIDTH+1 cycles after start.
// Backpressure: stall holds MDU/MFHI/MFLO in EX while the engine is busy.
module alu_ctl_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    alu_ctl_mdu_if.slave bus
);
    logic [3:0] ctl;
    logic       rtype, is_mdu, is_mf, start, busy;

    always_comb begin
        ctl = CTL_AND;
        case (alu_op_e'(bus.alu_op))
            AOP_ADD: ctl = CTL_ADD;
            AOP_SUB: ctl = CTL_SUB;
            AOP_RTYPE: begin
                case (bus.funct)
                    F_ADD:   ctl = CTL_ADD;
                    F_SUB:   ctl = CTL_SUB;
                    F_AND:   ctl = CTL_AND;
                    F_OR:    ctl = CTL_OR;
                    F_SLT:   ctl = CTL_SLT;
                    F_SLL:   ctl = CTL_SLL;
                    F_SRL:   ctl = CTL_SRL;
                    F_JR:    ctl = CTL_ADD;
                    default: ctl = CTL_AND;
                endcase
            end
            default: ctl = CTL_AND;
        endcase
    end

    assign bus.alu_ctl   = CTL_W'(ctl);
    assign rtype         = (bus.alu_op == AOP_RTYPE);
    assign is_mdu        = rtype & is_mdu_funct(bus.funct);
    assign is_mf         = rtype & ((bus.funct == F_MFHI) | (bus.funct == F_MFLO));
    assign bus.hi_lo_sel = {rtype & (bus.funct == F_MFHI), rtype & (bus.funct == F_MFLO)};
    assign start         = bus.valid_in & is_mdu & ~busy;
    // Only HI/LO consumers and new MDU ops wait; other instructions flow past.
    assign bus.stall     = bus.valid_in & busy & (is_mdu | is_mf);
    assign bus.busy      = busy;

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (mdu_op_e'(bus.funct[1:0])),
        .a     (bus.rs_val),
        .b     (bus.rt_val),
        .hi    (bus.hi),
        .lo    (bus.lo),
        .done  (bus.mdu_done),
        .busy  (busy)
    );

endmodule

// File: tb/tb_alu_ctl_mdu.sv
// Self-checking bench: decode table, directed MDU corner cases, randomized ops vs model.
module tb_alu_ctl_mdu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_hi = '0, last_lo = '0;

    always #5 clk = ~clk;

    alu_ctl_mdu_if #(.WIDTH(32), .CTL_W(4)) bus ();

    alu_ctl_mdu #(.WIDTH(32), .CTL_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] ctl;
        logic [1:0] sel;
    } dec_vec_t;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a, b, eh, el;
    } mdu_vec_t;

    dec_vec_t dv[16];
    mdu_vec_t mv[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        bus.valid_in = v;
        bus.alu_op   = op;
        bus.funct    = f;
        bus.rs_val   = a;
        bus.rt_val   = b;
    endtask

    // Reference: plain SV arithmetic on the MIPS HI/LO rules.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic [31:0] h, l;
        h = '0; l = '0;
        case (f)
            F_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {h, l} = sp;
            end
            F_MULTU: {h, l} = {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 0) begin h = a; l = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 0; l = a; end
                else begin h = $signed(a) % $signed(b); l = $signed(a) / $signed(b); end
            end
            default: begin
                if (b == 0) begin h = a; l = '1; end
                else begin h = a % b; l = a / b; end
            end
        endcase
        return {h, l};
    endfunction

    // Called just after the start edge; walks cycles T+1..T+33.
    task automatic track(input logic [31:0] eh, input logic [31:0] el, input bit mf,
                         input string nm);
        bit ok_busy = 1, ok_done = 1, ok_hold = 1, ok_mf = 1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 1) drive(0, AOP_ADD, 6'd0, 32'd0, 32'd0);
            if (mf && k == 3) begin
                drive(1, AOP_ADD, F_MFHI, 32'd1, 32'd2);
                #1 if (bus.stall !== 1'b0) ok_mf = 0;
            end
            if (mf && k == 5) drive(1, AOP_RTYPE, F_MFHI, 32'd0, 32'd0);
            #1;
            if (k <= 32) begin
                if (bus.busy !== 1'b1) ok_busy = 0;
                if (bus.mdu_done !== (k == 32)) ok_done = 0;
                if (bus.hi !== last_hi || bus.lo !== last_lo) ok_hold = 0;
                if (mf && k >= 5 && (bus.stall !== 1'b1 || bus.hi_lo_sel !== 2'b10)) ok_mf = 0;
            end
        end
        check({nm, " busy_seq"}, {31'd0, ok_busy}, 32'd1);
        check({nm, " done_seq"}, {31'd0, ok_done}, 32'd1);
        check({nm, " hold"}, {31'd0, ok_hold}, 32'd1);
        check({nm, " idle_after"}, {30'd0, bus.busy, bus.mdu_done}, 32'd0);
        check({nm, " hi"}, bus.hi, eh);
        check({nm, " lo"}, bus.lo, el);
        if (mf) begin
            check({nm, " mf_stall"}, {31'd0, ok_mf}, 32'd1);
            check({nm, " mf_release"}, {31'd0, bus.stall}, 32'd0);
        end
        last_hi = eh;
        last_lo = el;
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input bit mf,
                          input string nm);
        @(negedge clk);
        drive(1, AOP_RTYPE, f, a, b);
        #1 check({nm, " start_stall"}, {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        track(eh, el, mf, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] m;
        logic [31:0] ra, rb;
        logic [5:0]  rf;
        bit ok;

        dv[0]  = '{AOP_ADD,   6'b111111, CTL_ADD, 2'b00};
        dv[1]  = '{AOP_SUB,   F_ADD,     CTL_SUB, 2'b00};
        dv[2]  = '{AOP_RTYPE, F_ADD,     CTL_ADD, 2'b00};
        dv[3]  = '{AOP_RTYPE, F_SUB,     CTL_SUB, 2'b00};
        dv[4]  = '{AOP_RTYPE, F_AND,     CTL_AND, 2'b00};
        dv[5]  = '{AOP_RTYPE, F_OR,      CTL_OR,  2'b00};
        dv[6]  = '{AOP_RTYPE, F_SLT,     CTL_SLT, 2'b00};
        dv[7]  = '{AOP_RTYPE, F_SLL,     CTL_SLL, 2'b00};
        dv[8]  = '{AOP_RTYPE, F_SRL,     CTL_SRL, 2'b00};
        dv[9]  = '{AOP_RTYPE, F_JR,      CTL_ADD, 2'b00};
        dv[10] = '{AOP_RTYPE, F_MULT,    CTL_AND, 2'b00};
        dv[11] = '{AOP_RTYPE, F_DIVU,    CTL_AND, 2'b00};
        dv[12] = '{AOP_RTYPE, F_MFHI,    CTL_AND, 2'b10};
        dv[13] = '{AOP_RTYPE, F_MFLO,    CTL_AND, 2'b01};
        dv[14] = '{AOP_RSVD,  F_ADD,     CTL_AND, 2'b00};
        dv[15] = '{AOP_ADD,   F_MFHI,    CTL_ADD, 2'b00};

        mv[0] = '{F_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        mv[1] = '{F_MULTU, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
        mv[2] = '{F_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        mv[3] = '{F_DIVU,  32'd5,          32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        mv[4] = '{F_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};

        drive(0, AOP_ADD, 6'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy_done", {30'd0, bus.busy, bus.mdu_done}, 32'd0);
        reset = 1'b0;

        // Decode sweep with valid_in low: nothing may start.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(0, dv[i].op, dv[i].f, 32'd3, 32'd4);
            #1;
            check($sformatf("dec%0d ctl", i), {28'd0, bus.alu_ctl}, {28'd0, dv[i].ctl});
            check($sformatf("dec%0d sel", i), {30'd0, bus.hi_lo_sel}, {30'd0, dv[i].sel});
        end
        @(negedge clk);
        check("dec no_start", {31'd0, bus.busy}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            m = model(mv[i].f, mv[i].a, mv[i].b);
            check($sformatf("vec%0d model_hi", i), m[63:32], mv[i].eh);
            check($sformatf("vec%0d model_lo", i), m[31:0], mv[i].el);
            run_op(mv[i].f, mv[i].a, mv[i].b, mv[i].eh, mv[i].el, 1'b0, $sformatf("vec%0d", i));
        end

        m = model(F_MULT, 32'h0001_2345, 32'hFFFF_0003);
        run_op(F_MULT, 32'h0001_2345, 32'hFFFF_0003, m[63:32], m[31:0], 1'b1, "mfhi_stall");

        for (int i = 0; i < 20; i++) begin
            rf = 6'b011000 | 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = $urandom_range(1, 9);
                default: ;
            endcase
            m = model(rf, ra, rb);
            run_op(rf, ra, rb, m[63:32], m[31:0], 1'b0, $sformatf("rnd%0d", i));
        end

        // Second MULT held in EX while the first runs; it starts the cycle busy drops.
        @(negedge clk);
        drive(1, AOP_RTYPE, F_MULT, 32'hFFFF_FFF0, 32'd3);
        @(posedge clk);
        ok = 1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 1) drive(1, AOP_RTYPE, F_MULT, 32'd1000, 32'hFFFF_FFFF);
            #1 if (bus.stall !== 1'b1 || bus.hi !== last_hi) ok = 0;
        end
        check("held stall", {31'd0, ok}, 32'd1);
        @(negedge clk);
        #1;
        check("held release", {30'd0, bus.stall, bus.busy}, 32'd0);
        m = model(F_MULT, 32'hFFFF_FFF0, 32'd3);
        check("held first_hi", bus.hi, m[63:32]);
        check("held first_lo", bus.lo, m[31:0]);
        last_hi = m[63:32];
        last_lo = m[31:0];
        @(posedge clk);
        m = model(F_MULT, 32'd1000, 32'hFFFF_FFFF);
        track(m[63:32], m[31:0], 1'b0, "held second");

        // Reset partway through a DIVU aborts with no done pulse.
        @(negedge clk);
        drive(1, AOP_RTYPE, F_DIVU, 32'h1234_5678, 32'd7);
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) drive(0, AOP_ADD, 6'd0, 32'd0, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        ok = 1;
        for (int k = 12; k <= 34; k++) begin
            @(negedge clk);
            #1 if (bus.mdu_done !== 1'b0 || bus.busy !== 1'b0) ok = 0;
        end
        check("abort no_done", {31'd0, ok}, 32'd1);
        last_hi = '0;
        last_lo = '0;

        m = model(F_DIV, 32'd100, 32'hFFFF_FFF9);
        run_op(F_DIV, 32'd100, 32'hFFFF_FFF9, m[63:32], m[31:0], 1'b0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_ctl_mdu.md
Name: alu_ctl_mdu

Overview:
Next-generation EX-stage control block. It keeps the existing combinational ALU-control decode for alu_op/funct and adds the MIPS HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MFHI, MFLO). That unit is an iterative sequential engine with busy/stall handshake. The block sits beside the ALU in EX; its stall output feeds the hazard unit, which freezes IF/ID/EX.

Parameters:
WIDTH, 32, datapath width of rs/rt operands and of HI/LO
CTL_W, 4, width of alu_ctl output

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
valid_in  in  1  a valid instruction occupies EX this cycle
alu_op  in  2  00 ADD, 01 SUB, 10 R-type (decode funct), 11 reserved
funct  in  6  instruction funct field
rs_val  in  WIDTH  operand A / dividend / multiplicand
rt_val  in  WIDTH  operand B / divisor / multiplier
alu_ctl  out  CTL_W  ALU operation select (combinational)
hi_lo_sel  out  2  00 ALU result, 10 HI, 01 LO (combinational, to EX result mux)
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  MDU iteration in progress (registered)
stall  out  1  freeze pipeline this cycle (combinational)
mdu_done  out  1  one-cycle pulse in the final iteration cycle

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, mdu_done=0, engine state IDLE.
- alu_ctl decode (combinational, no latency):
  - alu_op 00 → 0010; 01 → 0110.
  - Under 10: funct 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111, 000000 → 1000, 000010 → 1001, 001000 → 0010.
  - All MDU functs and all other values → 0000. alu_op 11 → 0000.
- hi_lo_sel: 10 when alu_op=10 & funct=010000 (MFHI); 01 for 010010 (MFLO); else 00.
- MDU functs: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
- Start condition: valid_in & alu_op=10 & MDU funct & !busy. Operands are captured in start cycle T.
- FSM IDLE → RUN → IDLE:
  - RUN lasts WIDTH cycles (T+1..T+WIDTH); busy=1 throughout.
  - mdu_done=1 in cycle T+WIDTH.
  - hi/lo update at the end of T+WIDTH and are visible from T+WIDTH+1, when busy=0.
- Multiply: shift-add, one bit per cycle. 2*WIDTH-bit product: hi=upper half, lo=lower half. Signed ops work on magnitudes and negate the product if operand signs differ.
- Divide: restoring, one quotient bit per cycle. lo=quotient, hi=remainder. Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (rt_val=0): full WIDTH cycles still run; lo=all ones, hi=rs_val.
- Signed MIN / -1: lo=MIN, hi=0.
- stall = valid_in & alu_op=10 & busy & (MDU funct or MFHI or MFLO). Other instructions proceed while busy.
- A start request while busy is ignored; stall holds it until busy drops, then it starts normally.
- Reset mid-operation: aborts immediately. hi/lo=0, busy=0, no mdu_done pulse.
- Back-to-back ops: a new start is legal in cycle T+WIDTH+1.

Decomposition:
- Package alu_pkg:
  - alu_ctl code constants (ADD, SUB, AND, OR, SLT, SLL, SRL).
  - funct constants, including MDU, MFHI and MFLO.
  - alu_op encodings.
  - MDU state enum {IDLE, RUN}.
- One sub-module, mdu_iter: the iterative mul/div engine.
  - Inputs: start, op, operands.
  - Outputs: hi/lo results, done, busy.
  - Decode and stall logic stay in the top module.

Test Plan:
- Legacy decode sweep: every alu_op/funct pair listed above gives its alu_ctl code; funct 011000 with alu_op=10 → 0000; alu_op=11 → 0000.
- MULT 7 × 0xFFFFFFFD at T → busy T+1..T+32, mdu_done at T+32; hi=0xFFFFFFFF, lo=0xFFFFFFEB at T+33. MULTU 0xFFFFFFFF × 2 → hi=1, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MFHI presented at T+5 of a MULT → stall=1 through T+32, hi_lo_sel=10. ADD presented while busy → stall=0.
- Reset asserted at T+10 of a DIVU → next cycle busy=0, hi=lo=0; no mdu_done at T+32.
- MULT held in EX while busy → stall until busy drops; starts the cycle busy=0; second result correct; first result not overwritten early.
